adder_nbit_serial: RTL and testbench

//  Parametrised multi-cycle adder: A + B + carry_in over WIDTH bits, BITS_PER_CYCLE bits per clock.
//  - Operands are latched on a start handshake; the result is presented with a one-cycle done pulse.
//  - Provides a signed-overflow flag.
//  - Low-area arithmetic unit: used where a WIDTH-bit ripple adder is too costly.

---
 rtl/adder_nbit_serial_pkg.sv | 27 ++
 rtl/adder_nbit_serial_if.sv | 32 +++
 rtl/adder_1bit.sv | 23 ++
 rtl/adder_nbit_serial_slice.sv | 39 +++
 rtl/adder_nbit_serial.sv | 144 ++++++++++++++
 tb/tb_adder_nbit_serial.sv | 285 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/adder_nbit_serial_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared types and elaboration helpers for the serial N-bit adder.
//   - adder_state_t : FSM state encoding (IDLE, RUN, DONE)
//   - params_ok     : legality check for WIDTH / BITS_PER_CYCLE
//   - cnt_width     : width of the RUN-cycle counter for a given cycle count
// ----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } adder_state_t;

   // The slice must tile the operand exactly, otherwise the last RUN cycle
   // would add a partial slice and the counter terminal value is meaningless.
   function automatic bit params_ok(input int width, input int bpc);
      return (width >= 2) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
   endfunction

   // A single-cycle configuration (N == 1) still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder_nbit_serial_if.sv
// ----------------------------------------------------------------------------
// adder_nbit_serial_if
//   Request/result bundle of the serial adder.
//   master : drives start, a, b, carry_in; observes busy, done, sum,
//            carry_out, overflow
//   slave  : the adder itself (mirror directions)
// ----------------------------------------------------------------------------
interface adder_nbit_serial_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, a, b, carry_in,
      input  busy, done, sum, carry_out, overflow
   );

   modport slave (
      input  start, a, b, carry_in,
      output busy, done, sum, carry_out, overflow
   );

endinterface

// File: rtl/adder_1bit.sv
// ----------------------------------------------------------------------------
// adder_1bit
//   Full-adder cell.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
// ----------------------------------------------------------------------------
module adder_1bit (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic p;

   assign p   = a_i ^ b_i;
   assign s_o = p ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/adder_nbit_serial_slice.sv
// ----------------------------------------------------------------------------
// adder_slice
//   Combinational BPC-bit ripple chain of adder_1bit cells; this is the
//   per-cycle datapath of the serial adder.
//   a_i, b_i : BPC-bit operand slices
//   c_i      : carry in to bit 0
//   s_o      : BPC-bit partial sum
//   c_o      : carry out of the top bit
//   c_top_o  : carry into the top bit (signed overflow on the last slice)
// ----------------------------------------------------------------------------
module adder_slice #(
   parameter int BPC = 1
) (
   input  logic [BPC-1:0] a_i,
   input  logic [BPC-1:0] b_i,
   input  logic           c_i,
   output logic [BPC-1:0] s_o,
   output logic           c_o,
   output logic           c_top_o
);

   logic [BPC:0] c;

   assign c[0] = c_i;

   for (genvar i = 0; i < BPC; i++) begin : g_bit
      adder_1bit u_fa (
         .a_i (a_i[i]),
         .b_i (b_i[i]),
         .c_i (c[i]),
         .s_o (s_o[i]),
         .c_o (c[i+1])
      );
   end

   assign c_o     = c[BPC];
   assign c_top_o = c[BPC-1];

endmodule

// File: rtl/adder_nbit_serial.sv
// ----------------------------------------------------------------------------
// adder_nbit_serial
//   Multi-cycle adder computing a + b + carry_in over WIDTH bits,
//   BITS_PER_CYCLE bits per clock. Operands are captured on an accepted
//   start; the result appears with a one-cycle done pulse and then holds.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : adder_nbit_serial_if slave (start/a/b/carry_in in,
//          busy/done/sum/carry_out/overflow out)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no operation in flight, outputs hold last result
//   RUN   | one slice summed per edge, N edges in total
//   DONE  | result just loaded, done high; start here chains next op
// ----------------------------------------------------------------------------
module adder_nbit_serial
   import adder_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   adder_nbit_serial_if.slave bus
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = cnt_width(N);
   localparam int BPC   = BITS_PER_CYCLE;

   if (!params_ok(WIDTH, BITS_PER_CYCLE)) begin : g_param_check
      $error("adder_nbit_serial: WIDTH=%0d BITS_PER_CYCLE=%0d illegal", WIDTH, BITS_PER_CYCLE);
   end

   adder_state_t     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic [BPC-1:0]   part_sum;
   logic             slice_cout;
   logic             slice_ctop;
   logic             last_run;

   adder_slice #(
      .BPC (BPC)
   ) u_slice (
      .a_i     (a_q[BPC-1:0]),
      .b_i     (b_q[BPC-1:0]),
      .c_i     (carry_q),
      .s_o     (part_sum),
      .c_o     (slice_cout),
      .c_top_o (slice_ctop)
   );

   // Partial sums enter at the top so that after N shifts the first slice
   // has walked down to bit 0.
   if (BPC == WIDTH) begin : g_acc_full
      assign acc_d = part_sum;
   end else begin : g_acc_shift
      assign acc_d = {part_sum, acc_q[WIDTH-1:BPC]};
   end

   assign last_run = (cnt_q == CNT_W'(N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= bus.carry_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= a_q >> BPC;
               b_q     <= b_q >> BPC;
               carry_q <= slice_cout;
               acc_q   <= acc_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_run) begin
                  // On the final slice its top bit is the MSB of the word.
                  sum_q   <= acc_d;
                  cout_q  <= slice_cout;
                  ovf_q   <= slice_cout ^ slice_ctop;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;

   // Simulation-only input sanity checks.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!$isunknown(bus.start))
            else $error("adder_nbit_serial: start is X/Z");
         assert (!$isunknown(bus.carry_in))
            else $error("adder_nbit_serial: carry_in is X/Z");
      end
   end

endmodule

// File: tb/tb_adder_nbit_serial.sv
module tb_adder_nbit_serial;

   localparam int W1 = 8;
   localparam int B1 = 1;
   localparam int N1 = W1 / B1;
   localparam int W2 = 16;
   localparam int B2 = 4;
   localparam int RAND_OPS = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adder_nbit_serial_if #(.WIDTH(W1)) bus1 ();
   adder_nbit_serial_if #(.WIDTH(W2)) bus2 ();

   adder_nbit_serial #(.WIDTH(W1), .BITS_PER_CYCLE(B1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   adder_nbit_serial #(.WIDTH(W2), .BITS_PER_CYCLE(B2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: returns {overflow, carry_out, sum[15:0]} for a w-bit add.
   function automatic logic [17:0] ref_add(input longint a, input longint b,
                                           input longint cin, input int w);
      longint m, u, sa, sb, ts;
      logic [15:0] s16;
      logic cout, ovf;
      m    = longint'(1) << w;
      u    = a + b + cin;
      s16  = 16'(u % m);
      cout = (u >= m);
      sa   = (a >= m / 2) ? a - m : a;
      sb   = (b >= m / 2) ? b - m : b;
      ts   = sa + sb + cin;
      ovf  = (ts >= m / 2) || (ts < -(m / 2));
      return {ovf, cout, s16};
   endfunction

   // Transaction-level model of dut1: an accepted op completes N1 edges
   // after its accept edge; outputs hold between completions.
   int         edge_no   = 0;
   bit         m_pend    = 1'b0;
   int         m_due     = 0;
   logic [7:0] m_psum    = '0;
   bit         m_pcout   = 1'b0;
   bit         m_povf    = 1'b0;
   logic [7:0] m_sum     = '0;
   bit         m_cout    = 1'b0;
   bit         m_ovf     = 1'b0;
   bit         m_done    = 1'b0;
   bit         m_busy    = 1'b0;
   int         m_accepts = 0;

   initial begin
      logic [17:0] r;
      bit pre;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_pend = 1'b0; m_done = 1'b0; m_busy = 1'b0;
            m_sum  = '0;   m_cout = 1'b0; m_ovf  = 1'b0;
         end else begin
            edge_no++;
            pre    = m_pend;
            m_done = 1'b0;
            if (pre && edge_no == m_due) begin
               m_sum  = m_psum;
               m_cout = m_pcout;
               m_ovf  = m_povf;
               m_done = 1'b1;
               m_pend = 1'b0;
            end
            if (!pre && bus1.start) begin
               r = ref_add(longint'(bus1.a), longint'(bus1.b), longint'(bus1.carry_in), W1);
               m_psum  = r[7:0];
               m_pcout = r[16];
               m_povf  = r[17];
               m_pend  = 1'b1;
               m_due   = edge_no + N1;
               m_accepts++;
            end
            m_busy = m_pend;
         end
      end
   end

   // Every-cycle comparison of dut1 against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("cyc_busy", longint'(bus1.busy),      longint'(m_busy));
         chk("cyc_done", longint'(bus1.done),      longint'(m_done));
         chk("cyc_sum",  longint'(bus1.sum),       longint'(m_sum));
         chk("cyc_cout", longint'(bus1.carry_out), longint'(m_cout));
         chk("cyc_ovf",  longint'(bus1.overflow),  longint'(m_ovf));
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Single op on dut1; lat = edges from accept edge to the done cycle.
   task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output int lat);
      int n;
      bus1.a = a; bus1.b = b; bus1.carry_in = cin; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      n = 1;
      while (!bus1.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("op1_done_seen", longint'(bus1.done), 1);
      lat = n - 1;
   endtask

   task automatic op2(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      output int lat);
      int n;
      bus2.a = a; bus2.b = b; bus2.carry_in = cin; bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      n = 1;
      while (!bus2.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("op2_done_seen", longint'(bus2.done), 1);
      lat = n - 1;
   endtask

   initial begin
      int lat, gap, base, cyc, done_seen;
      logic [17:0] r;
      logic [15:0] ra, rb;
      logic        rc;

      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.carry_in = 1'b0;
      bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.carry_in = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_busy", longint'(bus1.busy), 0);
      chk("rst_done", longint'(bus1.done), 0);
      chk("rst_sum",  longint'(bus1.sum),  0);
      chk("rst_sum2", longint'(bus2.sum),  0);
      rst = 1'b0;
      @(negedge clk);

      // Pin the reference model with hand-computed values.
      r = ref_add(64'h35, 64'h4A, 0, 8);
      chk("ref_35_4a", longint'(r), longint'(18'h0007F));
      r = ref_add(64'h7F, 64'h01, 0, 8);
      chk("ref_7f_01", longint'(r), longint'(18'h20080));

      // Basic op, latency N1 after accept.
      op1(8'h35, 8'h4A, 1'b0, lat);
      chk("t1_lat",  lat, 8);
      chk("t1_sum",  longint'(bus1.sum), 64'h7F);
      chk("t1_cout", longint'(bus1.carry_out), 0);
      chk("t1_ovf",  longint'(bus1.overflow), 0);

      op1(8'hFF, 8'h00, 1'b1, lat);
      chk("t2a_sum",  longint'(bus1.sum), 64'h00);
      chk("t2a_cout", longint'(bus1.carry_out), 1);
      chk("t2a_ovf",  longint'(bus1.overflow), 0);

      op1(8'h7F, 8'h01, 1'b0, lat);
      chk("t2b_sum",  longint'(bus1.sum), 64'h80);
      chk("t2b_cout", longint'(bus1.carry_out), 0);
      chk("t2b_ovf",  longint'(bus1.overflow), 1);

      // Start held across DONE chains the next op; RUN-time changes ignored.
      bus1.a = 8'h12; bus1.b = 8'h34; bus1.carry_in = 1'b1; bus1.start = 1'b1;
      @(negedge clk);
      cyc = 0;
      while (!bus1.done && cyc < 40) begin
         bus1.a = 8'($urandom); bus1.b = 8'($urandom);
         @(negedge clk);
         cyc++;
      end
      chk("t3_first_done", longint'(bus1.done), 1);
      chk("t3_sum1", longint'(bus1.sum), 64'h47);
      bus1.a = 8'h80; bus1.b = 8'h80; bus1.carry_in = 1'b0;
      @(negedge clk);
      bus1.start = 1'b0;
      gap = 1;
      while (!bus1.done && gap < 40) begin
         bus1.a = 8'($urandom); bus1.b = 8'($urandom);
         bus1.start = 1'($urandom);
         @(negedge clk);
         gap++;
      end
      bus1.start = 1'b0;
      chk("t3_gap",   gap, 9);
      chk("t3_sum2",  longint'(bus1.sum), 64'h00);
      chk("t3_cout2", longint'(bus1.carry_out), 1);
      chk("t3_ovf2",  longint'(bus1.overflow), 1);

      op1(8'h35, 8'h4A, 1'b0, lat);

      // Reset in RUN cycle 4 aborts without a done pulse.
      bus1.a = 8'h11; bus1.b = 8'h22; bus1.carry_in = 1'b0; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_busy_pre", longint'(bus1.busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("t4_busy", longint'(bus1.busy), 0);
      chk("t4_done", longint'(bus1.done), 0);
      chk("t4_sum",  longint'(bus1.sum),  0);
      chk("t4_cout", longint'(bus1.carry_out), 0);
      chk("t4_ovf",  longint'(bus1.overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus1.done) done_seen++;
      end
      chk("t4_no_done", done_seen, 0);
      op1(8'hC3, 8'h5A, 1'b1, lat);
      chk("t4_after_sum",  longint'(bus1.sum), 64'h1E);
      chk("t4_after_cout", longint'(bus1.carry_out), 1);
      chk("t4_after_ovf",  longint'(bus1.overflow), 0);

      // Four bits per cycle.
      op2(16'hFFFF, 16'h0001, 1'b0, lat);
      chk("t5_lat",  lat, 4);
      chk("t5_sum",  longint'(bus2.sum), 64'h0000);
      chk("t5_cout", longint'(bus2.carry_out), 1);
      chk("t5_ovf",  longint'(bus2.overflow), 0);
      op2(16'h7FFF, 16'h0001, 1'b0, lat);
      chk("t5b_sum", longint'(bus2.sum), 64'h8000);
      chk("t5b_ovf", longint'(bus2.overflow), 1);
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         op2(ra, rb, rc, lat);
         r = ref_add(longint'(ra), longint'(rb), longint'(rc), W2);
         chk("t5r_lat", lat, 4);
         chk("t5r_res", longint'({bus2.overflow, bus2.carry_out, bus2.sum}), longint'(r));
      end

      // Random traffic on dut1; the per-cycle compare checks every cycle.
      base = m_accepts;
      cyc  = 0;
      while ((m_accepts - base) < RAND_OPS && cyc < 40000) begin
         bus1.start    = ($urandom_range(0, 2) != 0);
         bus1.a        = 8'($urandom);
         bus1.b        = 8'($urandom);
         bus1.carry_in = 1'($urandom);
         @(negedge clk);
         cyc++;
      end
      chk("t6_ops_done", longint'((m_accepts - base) >= RAND_OPS), 1);
      bus1.start = 1'b0;
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
